// File: rtl/data_bus_ctrl_if.sv
// Core data-access bus and external peripheral port of data_bus_ctrl.
// Handshake: the core holds mem_req/mem_we/data_address/data_out stable while stall_proc is high; io_req (with io_we/io_addr/io_wdata) stays asserted until an enabled cycle samples io_ack.
interface data_bus_ctrl_if;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] data_address;
  logic [7:0] data_out;
  logic [7:0] data_in;
  logic       stall_proc;
  logic       io_req;
  logic       io_we;
  logic [3:0] io_addr;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       io_ack;
  logic       io_err;

  modport master (
    output mem_req, mem_we, data_address, data_out, io_rdata, io_ack,
    input  data_in, stall_proc, io_req, io_we, io_addr, io_wdata, io_err
  );

  modport slave (
    input  mem_req, mem_we, data_address, data_out, io_rdata, io_ack,
    output data_in, stall_proc, io_req, io_we, io_addr, io_wdata, io_err
  );
endinterface

// File: rtl/data_bus_ctrl.sv
// Data-side controller: 1-cycle RAM and LFSR accesses, stalled req/ack forwarding of high-page I/O.
// Optional macro IO_TIMEOUT_EN adds an I/O abort counter and the sticky io_err flag.
module data_bus_ctrl #(
  parameter int         RAM_DEPTH = 240,
  parameter logic [7:0] RNG_ADDR  = 8'hFE,
  parameter logic [7:0] RNG_SEED  = 8'hA5
`ifdef IO_TIMEOUT_EN
  , parameter int       TIMEOUT_CYCLES = 16
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_en,
  data_bus_ctrl_if.slave bus,
  output logic [1:0]     dbg_state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, IO_WAIT = 2'd1, IO_DONE = 2'd2} state_t;

  localparam logic [8:0] RAM_LIMIT = 9'(RAM_DEPTH);

  state_t     state_q;
  logic [7:0] data_in_q;
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       io_req_q;
  logic       io_we_q;
  logic [3:0] io_addr_q;
  logic [7:0] io_wdata_q;
  logic [7:0] ram_q [RAM_DEPTH];

  logic ram_hit;
  logic rng_hit;
  logic io_hit;
  logic idle_acc;

`ifdef IO_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_q;
  logic          io_err_q;
  logic          tmo_hit;
  assign tmo_hit    = (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign bus.io_err = io_err_q;
`else
  assign bus.io_err = 1'b0;
`endif

  always_comb begin
    ram_hit  = ({1'b0, bus.data_address} < RAM_LIMIT);
    rng_hit  = (bus.data_address == RNG_ADDR);
    io_hit   = (bus.data_address >= 8'hF0) && !rng_hit;
    idle_acc = (state_q == IDLE) && bus.mem_req;
    // Free-running shift; a core write replaces the shift on the same edge.
    lfsr_d   = {lfsr_q[6:0], ^(lfsr_q & 8'hB8)};
    if (idle_acc && bus.mem_we && rng_hit) begin
      lfsr_d = (bus.data_out == 8'h00) ? RNG_SEED : bus.data_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_in_q  <= 8'h00;
      lfsr_q     <= RNG_SEED;
      io_req_q   <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= 4'h0;
      io_wdata_q <= 8'h00;
`ifdef IO_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      io_err_q   <= 1'b0;
`endif
    end else if (clk_en) begin
      lfsr_q <= lfsr_d;
      case (state_q)
        IDLE: begin
          if (bus.mem_req) begin
            if (io_hit) begin
              state_q    <= IO_WAIT;
              io_req_q   <= 1'b1;
              io_we_q    <= bus.mem_we;
              io_addr_q  <= bus.data_address[3:0];
              io_wdata_q <= bus.data_out;
`ifdef IO_TIMEOUT_EN
              tmo_cnt_q  <= '0;
`endif
            end else if (!bus.mem_we) begin
              if (ram_hit)      data_in_q <= ram_q[bus.data_address];
              else if (rng_hit) data_in_q <= lfsr_q;
              else              data_in_q <= 8'h00;
            end
          end
        end
        IO_WAIT: begin
          // An ack coinciding with the timeout takes priority.
          if (bus.io_ack) begin
            if (!io_we_q) data_in_q <= bus.io_rdata;
            io_req_q <= 1'b0;
            state_q  <= IO_DONE;
          end
`ifdef IO_TIMEOUT_EN
          else if (tmo_hit) begin
            if (!io_we_q) data_in_q <= 8'h00;
            io_req_q <= 1'b0;
            io_err_q <= 1'b1;
            state_q  <= IO_DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        IO_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM has no reset; only accepted IDLE writes land.
  always_ff @(posedge clk) begin
    if (rst_n && clk_en && idle_acc && bus.mem_we && ram_hit) begin
      ram_q[bus.data_address] <= bus.data_out;
    end
  end

  assign bus.data_in    = data_in_q;
  assign bus.stall_proc = (state_q == IO_WAIT) || (idle_acc && io_hit);
  assign bus.io_req     = io_req_q;
  assign bus.io_we      = io_we_q;
  assign bus.io_addr    = io_addr_q;
  assign bus.io_wdata   = io_wdata_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_data_bus_ctrl.sv
// Bench for data_bus_ctrl: random RAM/RNG traffic and directed I/O handshake scenarios
// checked against a transaction-level model (RAM array, LFSR successor function, expected-data queue).
module tb_data_bus_ctrl;
  localparam int         RAM_DEPTH = 240;
  localparam logic [7:0] RNG_ADDR  = 8'hFE;
  localparam logic [7:0] RNG_SEED  = 8'hA5;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic [1:0] dbg_state;

  data_bus_ctrl_if bus();

  data_bus_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int io_req_rises = 0;

  logic [7:0] exp_ram [RAM_DEPTH];
  logic [7:0] m_lfsr = RNG_SEED;
  logic [7:0] m_din = 8'h00;
  logic [7:0] m_load_val = 8'h00;
  bit         m_load_pend = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge bus.io_req) io_req_rises++;

  // x^8+x^6+x^5+x^4+1: new bit is the parity of stages 8,6,5,4
  function automatic logic [7:0] lfsr_succ(input logic [7:0] x);
    return {x[6:0], ^(x & 8'hB8)};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_lfsr = RNG_SEED;
    else if (clk_en) m_lfsr = m_load_pend ? m_load_val : lfsr_succ(m_lfsr);
    m_load_pend = 1'b0;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.mem_req = 1'b0;
    bus.io_ack = 1'b0;
    clk_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    m_lfsr = RNG_SEED;
    m_din = 8'h00;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (bus.data_in !== 8'h00) begin n_err++; $display("FAIL rst_data_in got=%h exp=00", bus.data_in); end
    n_vec++; if (bus.stall_proc !== 1'b0) begin n_err++; $display("FAIL rst_stall got=%b exp=0", bus.stall_proc); end
    n_vec++; if (bus.io_req !== 1'b0) begin n_err++; $display("FAIL rst_io_req got=%b exp=0", bus.io_req); end
    n_vec++; if (bus.io_we !== 1'b0) begin n_err++; $display("FAIL rst_io_we got=%b exp=0", bus.io_we); end
    n_vec++; if (bus.io_addr !== 4'h0) begin n_err++; $display("FAIL rst_io_addr got=%h exp=0", bus.io_addr); end
    n_vec++; if (bus.io_wdata !== 8'h00) begin n_err++; $display("FAIL rst_io_wdata got=%h exp=00", bus.io_wdata); end
    n_vec++; if (bus.io_err !== 1'b0) begin n_err++; $display("FAIL rst_io_err got=%b exp=0", bus.io_err); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_ram();
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.data_address = 8'h10; bus.data_out = 8'h3C;
    #1;
    n_vec++; if (bus.stall_proc !== 1'b0) begin n_err++; $display("FAIL ram_wr_stall got=%b exp=0", bus.stall_proc); end
    tick();
    exp_ram[8'h10] = 8'h3C;
    bus.mem_we = 1'b0;
    tick();
    m_din = 8'h3C;
    n_vec++; if (bus.data_in !== 8'h3C) begin n_err++; $display("FAIL ram_rd_10 got=%h exp=3c", bus.data_in); end
    n_vec++; if (bus.stall_proc !== 1'b0) begin n_err++; $display("FAIL ram_rd_stall got=%b exp=0", bus.stall_proc); end
    // back-to-back preload of every RAM byte
    bus.mem_we = 1'b1;
    for (int a = 0; a < RAM_DEPTH; a++) begin
      bus.data_address = 8'(a);
      bus.data_out = 8'($urandom);
      exp_ram[a] = bus.data_out;
      tick();
    end
    // back-to-back random RAM/RNG traffic with clk_en dropouts
    for (int i = 0; i < 250; i++) begin
      logic [7:0] a;
      logic [7:0] v;
      bit         we;
      clk_en = ($urandom_range(0, 4) != 0);
      we = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 9) == 0) ? RNG_ADDR : 8'($urandom_range(0, RAM_DEPTH - 1));
      v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      bus.mem_req = 1'b1; bus.mem_we = we; bus.data_address = a; bus.data_out = v;
      if (clk_en) begin
        if (we && a == RNG_ADDR) begin m_load_pend = 1'b1; m_load_val = (v == 8'h00) ? RNG_SEED : v; end
        else if (we) exp_ram[a] = v;
        else m_din = (a == RNG_ADDR) ? m_lfsr : exp_ram[a];
      end
      tick();
      n_vec++; if (bus.data_in !== m_din) begin n_err++; $display("FAIL rand_rd i=%0d addr=%h we=%b en=%b got=%h exp=%h", i, a, we, clk_en, bus.data_in, m_din); end
      n_vec++; if (bus.stall_proc !== 1'b0) begin n_err++; $display("FAIL rand_stall i=%0d got=%b exp=0", i, bus.stall_proc); end
    end
    clk_en = 1'b1;
    bus.mem_req = 1'b0;
  endtask

  task automatic test_rng();
    apply_reset();
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.data_address = RNG_ADDR;
    m_din = m_lfsr;
    tick();
    n_vec++; if (bus.data_in !== 8'hA5) begin n_err++; $display("FAIL rng_first got=%h exp=a5", bus.data_in); end
    m_din = m_lfsr;
    tick();
    n_vec++; if (bus.data_in !== 8'h4A || m_din !== 8'h4A) begin n_err++; $display("FAIL rng_second got=%h exp=4a", bus.data_in); end
    bus.mem_we = 1'b1; bus.data_out = 8'h00;
    m_load_pend = 1'b1; m_load_val = RNG_SEED;
    tick();
    bus.mem_we = 1'b0;
    m_din = m_lfsr;
    tick();
    n_vec++; if (bus.data_in !== 8'hA5) begin n_err++; $display("FAIL rng_reseed got=%h exp=a5", bus.data_in); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'($urandom_range(1, 255));
      bus.mem_we = 1'b1; bus.data_out = v;
      m_load_pend = 1'b1; m_load_val = v;
      tick();
      bus.mem_we = 1'b0;
      tick();
      n_vec++; if (bus.data_in !== v) begin n_err++; $display("FAIL rng_load i=%0d got=%h exp=%h", i, bus.data_in, v); end
    end
    bus.mem_req = 1'b0;
  endtask

  task automatic test_io_read();
    for (int i = 0; i < 7; i++) begin
      logic [7:0] a;
      logic [7:0] rd;
      int         dly;
      int         rises0;
      a = (i == 0) ? 8'hF4 : {4'hF, 4'($urandom_range(0, 13))};
      rd = (i == 0) ? 8'h5A : 8'($urandom);
      dly = (i == 0) ? 3 : $urandom_range(1, 6);
      rises0 = io_req_rises;
      bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.data_address = a; bus.data_out = 8'($urandom);
      #1;
      n_vec++; if (bus.stall_proc !== 1'b1) begin n_err++; $display("FAIL io_rd_req_stall i=%0d got=%b exp=1", i, bus.stall_proc); end
      tick();
      n_vec++; if (bus.io_req !== 1'b1 || bus.io_we !== 1'b0) begin n_err++; $display("FAIL io_rd_issue i=%0d req=%b we=%b exp=1,0", i, bus.io_req, bus.io_we); end
      n_vec++; if (bus.io_addr !== a[3:0]) begin n_err++; $display("FAIL io_rd_addr i=%0d got=%h exp=%h", i, bus.io_addr, a[3:0]); end
      for (int k = 1; k < dly; k++) begin
        tick();
        n_vec++; if (bus.stall_proc !== 1'b1 || bus.io_req !== 1'b1 || dbg_state !== ST_WAIT) begin n_err++; $display("FAIL io_rd_wait i=%0d k=%0d stall=%b req=%b st=%0d exp=1,1,%0d", i, k, bus.stall_proc, bus.io_req, dbg_state, ST_WAIT); end
      end
      bus.io_ack = 1'b1; bus.io_rdata = rd;
      exp_q.push_back(rd);
      tick();
      bus.io_ack = 1'b0; bus.io_rdata = 8'($urandom);
      m_din = exp_q.pop_front();
      n_vec++; if (bus.data_in !== m_din) begin n_err++; $display("FAIL io_rd_data i=%0d got=%h exp=%h", i, bus.data_in, m_din); end
      n_vec++; if (bus.stall_proc !== 1'b0 || bus.io_req !== 1'b0 || dbg_state !== ST_DONE) begin n_err++; $display("FAIL io_rd_done i=%0d stall=%b req=%b st=%0d exp=0,0,%0d", i, bus.stall_proc, bus.io_req, dbg_state, ST_DONE); end
      tick();
      n_vec++; if (dbg_state !== ST_IDLE || bus.io_req !== 1'b0) begin n_err++; $display("FAIL io_rd_noreissue i=%0d st=%0d req=%b exp=%0d,0", i, dbg_state, bus.io_req, ST_IDLE); end
      n_vec++; if (io_req_rises !== rises0 + 1) begin n_err++; $display("FAIL io_rd_pulses i=%0d got=%0d exp=%0d", i, io_req_rises - rises0, 1); end
      bus.mem_req = 1'b0;
    end
    bus.io_ack = 1'b1; bus.io_rdata = ~m_din;
    tick();
    bus.io_ack = 1'b0;
    n_vec++; if (bus.data_in !== m_din || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL stray_ack data=%h st=%0d exp=%h,%0d", bus.data_in, dbg_state, m_din, ST_IDLE); end
  endtask

  task automatic test_io_write_clk_en();
    int rises0;
    rises0 = io_req_rises;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.data_address = 8'hF2; bus.data_out = 8'h77;
    tick();
    n_vec++; if (bus.io_we !== 1'b1 || bus.io_wdata !== 8'h77 || bus.io_addr !== 4'h2) begin n_err++; $display("FAIL io_wr_issue we=%b wdata=%h addr=%h exp=1,77,2", bus.io_we, bus.io_wdata, bus.io_addr); end
    for (int k = 0; k < 8; k++) begin
      clk_en = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.io_ack = !clk_en;
      tick();
      n_vec++; if (dbg_state !== ST_WAIT || bus.io_req !== 1'b1 || bus.stall_proc !== 1'b1) begin n_err++; $display("FAIL io_wr_frozen k=%0d st=%0d req=%b stall=%b exp=%0d,1,1", k, dbg_state, bus.io_req, bus.stall_proc, ST_WAIT); end
    end
    clk_en = 1'b1; bus.io_ack = 1'b1; bus.io_rdata = 8'($urandom);
    tick();
    bus.io_ack = 1'b0;
    n_vec++; if (dbg_state !== ST_DONE || bus.stall_proc !== 1'b0 || bus.data_in !== m_din) begin n_err++; $display("FAIL io_wr_done st=%0d stall=%b data=%h exp=%0d,0,%h", dbg_state, bus.stall_proc, bus.data_in, ST_DONE, m_din); end
    tick();
    bus.mem_req = 1'b0;
    n_vec++; if (io_req_rises !== rises0 + 1) begin n_err++; $display("FAIL io_wr_pulses got=%0d exp=1", io_req_rises - rises0); end
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.data_address = 8'h02;
    m_din = exp_ram[8'h02];
    tick();
    bus.mem_req = 1'b0;
    n_vec++; if (bus.data_in !== m_din) begin n_err++; $display("FAIL io_wr_ram_untouched got=%h exp=%h", bus.data_in, m_din); end
  endtask

  task automatic test_io_wait();
    logic [7:0] rd;
    rd = 8'($urandom);
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.data_address = 8'hF1;
    tick();
`ifdef IO_TIMEOUT_EN
    for (int k = 0; k < 15; k++) tick();
    n_vec++; if (dbg_state !== ST_WAIT) begin n_err++; $display("FAIL tmo_early st=%0d exp=%0d", dbg_state, ST_WAIT); end
    bus.io_ack = 1'b1; bus.io_rdata = rd;
    tick();
    bus.io_ack = 1'b0;
    n_vec++; if (bus.data_in !== rd || bus.io_err !== 1'b0 || dbg_state !== ST_DONE) begin n_err++; $display("FAIL tmo_ack_wins data=%h err=%b st=%0d exp=%h,0,%0d", bus.data_in, bus.io_err, dbg_state, rd, ST_DONE); end
    tick();
    bus.mem_req = 1'b0;
    #1;
    bus.mem_req = 1'b1;
    tick();
    begin
      int en_cnt;
      en_cnt = 0;
      for (int g = 0; g < 200 && en_cnt < 15; g++) begin
        clk_en = 1'($urandom_range(0, 1));
        tick();
        if (clk_en) en_cnt++;
      end
      clk_en = 1'b1;
    end
    n_vec++; if (dbg_state !== ST_WAIT || bus.stall_proc !== 1'b1) begin n_err++; $display("FAIL tmo_pre st=%0d stall=%b exp=%0d,1", dbg_state, bus.stall_proc, ST_WAIT); end
    tick();
    n_vec++; if (bus.data_in !== 8'h00 || bus.io_err !== 1'b1 || bus.stall_proc !== 1'b0 || bus.io_req !== 1'b0) begin n_err++; $display("FAIL tmo_abort data=%h err=%b stall=%b req=%b exp=00,1,0,0", bus.data_in, bus.io_err, bus.stall_proc, bus.io_req); end
    m_din = 8'h00;
    tick();
    bus.mem_req = 1'b0;
    tick();
    n_vec++; if (bus.io_err !== 1'b1 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL tmo_sticky err=%b st=%0d exp=1,%0d", bus.io_err, dbg_state, ST_IDLE); end
`else
    for (int k = 0; k < 24; k++) begin
      tick();
      n_vec++; if (dbg_state !== ST_WAIT || bus.stall_proc !== 1'b1) begin n_err++; $display("FAIL long_wait k=%0d st=%0d stall=%b exp=%0d,1", k, dbg_state, bus.stall_proc, ST_WAIT); end
    end
    bus.io_ack = 1'b1; bus.io_rdata = rd;
    tick();
    bus.io_ack = 1'b0;
    m_din = rd;
    n_vec++; if (bus.data_in !== rd || bus.io_err !== 1'b0 || dbg_state !== ST_DONE) begin n_err++; $display("FAIL long_wait_done data=%h err=%b st=%0d exp=%h,0,%0d", bus.data_in, bus.io_err, dbg_state, rd, ST_DONE); end
    tick();
    bus.mem_req = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_access();
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.data_address = 8'hF6;
    tick();
    n_vec++; if (bus.io_req !== 1'b1) begin n_err++; $display("FAIL mid_rst_issue got=%b exp=1", bus.io_req); end
    rst_n = 1'b0; bus.mem_req = 1'b0;
    #1;
    n_vec++; if (bus.io_req !== 1'b0 || bus.stall_proc !== 1'b0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL mid_rst_async req=%b stall=%b st=%0d exp=0,0,%0d", bus.io_req, bus.stall_proc, dbg_state, ST_IDLE); end
    tick();
    rst_n = 1'b1;
    m_lfsr = RNG_SEED;
    m_din = 8'h00;
    bus.io_ack = 1'b1; bus.io_rdata = 8'hAB;
    tick();
    bus.io_ack = 1'b0;
    n_vec++; if (bus.data_in !== 8'h00 || dbg_state !== ST_IDLE || bus.io_req !== 1'b0 || bus.stall_proc !== 1'b0) begin n_err++; $display("FAIL mid_rst_late_ack data=%h st=%0d req=%b stall=%b exp=00,%0d,0,0", bus.data_in, dbg_state, bus.io_req, bus.stall_proc, ST_IDLE); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.data_address = 8'h00; bus.data_out = 8'h00;
    bus.io_rdata = 8'h00; bus.io_ack = 1'b0;
    test_reset();
    test_ram();
    test_rng();
    test_io_read();
    test_io_write_clk_en();
    test_io_wait();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
